// File: rtl/trap_pulse_analyzer.sv
// trap_pulse_analyzer
//   Turns each pulse in the trapezoidal filter output stream into one event
//   record (flat-top amplitude, peak, trigger timestamp, pile-up flag) and
//   hands it to the readout over a valid/ready handshake.
//
//   Build option: define PILEUP_REJECT_EN to discard piled-up events instead
//   of emitting them (evt_pileup is then tied to 0).
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   synchronous, active-low
//   enable        in   1 = detection active
//   threshold     in   signed trigger level, compared every cycle
//   filter_data   in   signed shaped sample, one per clk
//   evt_valid     out  event record present
//   evt_ready     in   consumer accepts the record
//   evt_amp       out  sample at trigger + SAMPLE_DLY
//   evt_peak      out  max sample over trigger .. trigger + SAMPLE_DLY
//   evt_ts        out  timestamp of the trigger cycle
//   evt_pileup    out  second crossing seen during holdoff
//   drop_count    out  events lost to a busy output (saturating)
//   pileup_count  out  pile-up events seen (saturating)
module trap_pulse_analyzer #(
  parameter int unsigned SIZE_ADC_DATA = 16,
  parameter int unsigned SAMPLE_DLY    = 10,
  parameter int unsigned HOLDOFF       = 20,
  parameter int unsigned TS_W          = 32,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SIZE_ADC_DATA-1:0] threshold,
  input  logic [SIZE_ADC_DATA-1:0] filter_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [SIZE_ADC_DATA-1:0] evt_amp,
  output logic [SIZE_ADC_DATA-1:0] evt_peak,
  output logic [TS_W-1:0]          evt_ts,
  output logic                     evt_pileup,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         pileup_count
);

  localparam int unsigned DLY_W = 8;
  localparam logic [DLY_W-1:0] SAMPLE_DLY_C = DLY_W'(SAMPLE_DLY);
  localparam logic [DLY_W-1:0] HOLDOFF_C    = DLY_W'(HOLDOFF);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FLAT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  // Registered state
  logic [1:0]                      state;
  logic [DLY_W-1:0]                cnt;
  logic signed [SIZE_ADC_DATA-1:0] d0;
  logic signed [SIZE_ADC_DATA-1:0] peak;
  logic signed [SIZE_ADC_DATA-1:0] amp;
  logic [TS_W-1:0]                 ts_cnt;
  logic [TS_W-1:0]                 ts_lat;
  logic                            pu;
  logic                            armed;
  logic                            prev_above;

  // Next-state values
  logic [1:0]                      state_nx;
  logic [DLY_W-1:0]                cnt_nx;
  logic signed [SIZE_ADC_DATA-1:0] peak_nx;
  logic signed [SIZE_ADC_DATA-1:0] amp_nx;
  logic [TS_W-1:0]                 ts_lat_nx;
  logic                            pu_nx;
  logic                            armed_nx;

  logic above_c;
  logic emit_c;
  logic load_c;
  logic drop_c;
  logic pileup_c;

  assign above_c = d0 > $signed(threshold);

  // Input sample register, crossing history and free-running timestamp
  always_ff @(posedge clk) begin
    if (!reset) begin
      d0         <= '0;
      prev_above <= 1'b0;
      ts_cnt     <= '0;
    end else begin
      d0         <= $signed(filter_data);
      prev_above <= above_c;
      ts_cnt     <= ts_cnt + TS_W'(1);
    end
  end

  // FSM and event working registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      peak   <= '0;
      amp    <= '0;
      ts_lat <= '0;
      pu     <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      peak   <= peak_nx;
      amp    <= amp_nx;
      ts_lat <= ts_lat_nx;
      pu     <= pu_nx;
      armed  <= armed_nx;
    end
  end

  // Next-state and event datapath
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    peak_nx   = peak;
    amp_nx    = amp;
    ts_lat_nx = ts_lat;
    pu_nx     = pu;
    armed_nx  = 1'b0;
    emit_c    = 1'b0;

    case (state)
      ST_IDLE: begin
        // armed means the previous idle sample was already above threshold
        armed_nx = above_c;
        if (armed && above_c) begin
          armed_nx  = 1'b0;
          ts_lat_nx = ts_cnt;
          peak_nx   = d0;
          pu_nx     = 1'b0;
          cnt_nx    = DLY_W'(1);
          state_nx  = ST_FLAT;
        end
      end

      ST_FLAT: begin
        if (d0 > peak) begin
          peak_nx = d0;
        end
        cnt_nx = cnt + DLY_W'(1);
        if (cnt == SAMPLE_DLY_C) begin
          amp_nx   = d0;
          cnt_nx   = '0;
          state_nx = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (above_c && !prev_above) begin
          pu_nx = 1'b1;
        end
        // saturate so a long pile-up cannot wrap the holdoff count
        if (cnt != '1) begin
          cnt_nx = cnt + DLY_W'(1);
        end
        if ((cnt >= HOLDOFF_C) && !above_c) begin
          state_nx = ST_EMIT;
        end
      end

      ST_EMIT: begin
        emit_c   = 1'b1;
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // disabling abandons any in-flight event without counting it
    if (!enable) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      pu_nx    = 1'b0;
      armed_nx = 1'b0;
      emit_c   = 1'b0;
    end
  end

  assign pileup_c = emit_c && pu;

`ifdef PILEUP_REJECT_EN
  // piled-up events are rejected: neither loaded nor counted as drops
  assign load_c     = emit_c && !pu && (!evt_valid || evt_ready);
  assign drop_c     = emit_c && !pu && evt_valid && !evt_ready;
  assign evt_pileup = 1'b0;
`else
  assign load_c = emit_c && (!evt_valid || evt_ready);
  assign drop_c = emit_c && evt_valid && !evt_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      evt_pileup <= 1'b0;
    end else if (load_c) begin
      evt_pileup <= pu;
    end
  end
`endif

  // Output record; a load on an accept cycle replaces the record with no bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_amp   <= '0;
      evt_peak  <= '0;
      evt_ts    <= '0;
    end else if (load_c) begin
      evt_valid <= 1'b1;
      evt_amp   <= amp;
      evt_peak  <= peak_nx;
      evt_ts    <= ts_lat;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count   <= '0;
      pileup_count <= '0;
    end else begin
      if (drop_c && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      if (pileup_c && (pileup_count != '1)) begin
        pileup_count <= pileup_count + CNT_W'(1);
      end
    end
  end

endmodule
